// File: rtl/booth_pp_gen_if.sv
// booth_pp_gen_if: operand-in / partial-product-out handshake bundle.
// master drives a_i, b_i, in_valid, out_ready; slave drives the rest.
interface booth_pp_gen_if #(
  parameter int NA = 12,
  parameter int NB = 12
);
  localparam int NPP = NB / 2;

  logic [NA-1:0]        a_i;
  logic [NB-1:0]        b_i;
  logic                 in_valid;
  logic                 in_ready;
  logic [NPP-1:0][NA:0] pp_o;
  logic [NPP-1:0]       neg_o;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output a_i,
    output b_i,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  pp_o,
    input  neg_o,
    input  out_valid
  );

  modport slave (
    input  a_i,
    input  b_i,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output pp_o,
    output neg_o,
    output out_valid
  );
endinterface

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: radix-4 Booth recoder + partial-product generator, 2-stage valid/ready.
// Ports: clk, rst (async active-low), bus (slave): a_i,b_i,in_valid,in_ready,pp_o,neg_o,out_valid,out_ready.
module booth_pp_gen #(
  parameter int NA = 12,
  parameter int NB = 12
) (
  input  logic           clk,
  input  logic           rst,
  booth_pp_gen_if.slave  bus
);
  localparam int NPP = NB / 2;

  typedef struct packed {
    logic [NA-1:0]  a;
    logic [NPP-1:0] one;
    logic [NPP-1:0] two;
    logic [NPP-1:0] neg;
  } s1_t;

  logic                 s1_valid_q;
  logic                 s1_valid_d;
  s1_t                  s1_q;
  s1_t                  s1_d;
  s1_t                  rec;

  logic                 s2_valid_q;
  logic                 s2_valid_d;
  logic [NPP-1:0][NA:0] pp_q;
  logic [NPP-1:0][NA:0] pp_d;
  logic [NPP-1:0][NA:0] pp_new;
  logic [NPP-1:0]       neg_q;
  logic [NPP-1:0]       neg_d;

  logic                 s1_adv;
  logic                 s2_adv;
  logic [NB:0]          b_ext;

  // b[-1] = 0 appended below bit 0
  assign b_ext = {bus.b_i, 1'b0};

  always_comb begin
    rec   = '0;
    rec.a = bus.a_i;
    for (int i = 0; i < NPP; i++) begin
      unique case (b_ext[2*i +: 3])
        3'b001, 3'b010: rec.one[i] = 1'b1;
        3'b011:         rec.two[i] = 1'b1;
        3'b100: begin
          rec.two[i] = 1'b1;
          rec.neg[i] = 1'b1;
        end
        3'b101, 3'b110: begin
          rec.one[i] = 1'b1;
          rec.neg[i] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // One's complement here; the +1 travels separately on neg_o so that
  // -2 * (-2^(NA-1)) still fits in NA+1 bits.
  always_comb begin
    pp_new = '0;
    for (int i = 0; i < NPP; i++) begin
      pp_new[i] = (s1_q.one[i] ? {s1_q.a[NA-1], s1_q.a} :
                   s1_q.two[i] ? {s1_q.a, 1'b0} :
                   {(NA+1){1'b0}}) ^ {(NA+1){s1_q.neg[i]}};
    end
  end

  assign s2_adv = !s2_valid_q || bus.out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    pp_d       = pp_q;
    neg_d      = neg_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_d = rec;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        pp_d  = pp_new;
        neg_d = s1_q.neg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      pp_q       <= '0;
      neg_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      pp_q       <= pp_d;
      neg_q      <= neg_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.pp_o      = pp_q;
  assign bus.neg_o     = neg_q;
endmodule

// File: tb/tb_booth_pp_gen.sv
// tb_booth_pp_gen: directed and random checks of booth_pp_gen.
// Drives bus one step after each rising edge, samples in the same window.
module tb_booth_pp_gen;
  localparam int NA  = 12;
  localparam int NB  = 12;
  localparam int NPP = 6;

  typedef logic [NPP-1:0][NA:0] pp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  booth_pp_gen_if #(.NA(NA), .NB(NB)) bus ();

  booth_pp_gen #(.NA(NA), .NB(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic longint recon(input pp_t pp, input logic [NPP-1:0] ng);
    longint s = 0;
    for (int i = 0; i < NPP; i++) begin
      s += (longint'($signed(pp[i])) + longint'(ng[i])) <<< (2 * i);
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [11:0] a, input logic [11:0] b,
                       output logic ov, output pp_t pp,
                       output logic [NPP-1:0] ng, output logic rdy);
    bus.a_i       = a;
    bus.b_i       = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    rdy           = bus.in_ready;
    step();
    bus.in_valid  = 1'b0;
    step();
    ov = bus.out_valid;
    pp = bus.pp_o;
    ng = bus.neg_o;
  endtask

  task automatic test_reset();
    logic ov, rdy;
    pp_t pp, ex;
    logic [NPP-1:0] ng;
    rst           = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a_i       = 12'h001;
    bus.b_i       = 12'h001;
    bus.out_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.pp_o !== '0 || bus.neg_o !== '0) begin
      errors++;
      $display("FAIL reset_data: got pp=%h neg=%b expected 0", bus.pp_o, bus.neg_o);
    end
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    step();
    apply(12'h001, 12'h001, ov, pp, ng, rdy);
    ex    = '0;
    ex[0] = 13'h0001;
    checks++;
    if (rdy !== 1'b1 || ov !== 1'b1) begin
      errors++;
      $display("FAIL first_latency: got rdy=%b ov=%b expected 1 1", rdy, ov);
    end
    checks++;
    if (pp !== ex || ng !== 6'b000000) begin
      errors++;
      $display("FAIL first_pp: got pp=%h neg=%b expected pp=%h neg=000000", pp, ng, ex);
    end
  endtask

  task automatic test_vec(input string nm, input logic [11:0] a, input logic [11:0] b,
                          input pp_t ex, input logic [NPP-1:0] exn, input longint exp_p);
    logic ov, rdy;
    pp_t pp;
    logic [NPP-1:0] ng;
    apply(a, b, ov, pp, ng, rdy);
    checks++;
    if (ov !== 1'b1 || pp !== ex || ng !== exn) begin
      errors++;
      $display("FAIL %s: got ov=%b pp=%h neg=%b expected ov=1 pp=%h neg=%b",
               nm, ov, pp, ng, ex, exn);
    end
    checks++;
    if (recon(pp, ng) !== exp_p) begin
      errors++;
      $display("FAIL %s_product: got %0d expected %0d", nm, recon(pp, ng), exp_p);
    end
  endtask

  task automatic test_rows();
    pp_t ex;
    ex = '0;
    ex[0] = 13'h1001;
    ex[1] = 13'h07FF;
    test_vec("rows01", 12'h7FF, 12'h002, ex, 6'b000001, 64'sd4094);
  endtask

  task automatic test_corner();
    pp_t ex;
    ex = '0;
    ex[5] = 13'h0FFF;
    test_vec("corner", 12'h800, 12'h800, ex, 6'b100000, 64'sd4194304);
  endtask

  task automatic test_negmul();
    pp_t ex;
    ex = '0;
    ex[0] = 13'h1FFC;
    test_vec("negmul", 12'h003, 12'hFFF, ex, 6'b000001, -64'sd3);
    ex = '0;
    ex[0] = 13'h1DB9;
    test_vec("neg_two", 12'h123, 12'hFFE, ex, 6'b000001, -64'sd582);
  endtask

  task automatic test_back_to_back();
    pp_t snap;
    logic [NPP-1:0] nsnap;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a_i = 12'h001;
    bus.b_i = 12'h001;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept1: got %b expected 1", bus.in_ready);
    end
    step();
    bus.a_i = 12'h7FF;
    bus.b_i = 12'h002;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept2: got %b expected 1", bus.in_ready);
    end
    step();
    bus.a_i = 12'h003;
    bus.b_i = 12'hFFF;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: got rdy=%b ov=%b expected 0 1", bus.in_ready, bus.out_valid);
    end
    snap  = bus.pp_o;
    nsnap = bus.neg_o;
    checks++;
    if (recon(snap, nsnap) !== 64'sd1) begin
      errors++;
      $display("FAIL bp_head: got %0d expected 1", recon(snap, nsnap));
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.pp_o !== snap || bus.neg_o !== nsnap) begin
        errors++;
        $display("FAIL bp_hold%0d: got ov=%b rdy=%b pp=%h neg=%b expected 1 0 %h %b",
                 k, bus.out_valid, bus.in_ready, bus.pp_o, bus.neg_o, snap, nsnap);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_rdy: got %b expected 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || recon(bus.pp_o, bus.neg_o) !== 64'sd4094) begin
      errors++;
      $display("FAIL bp_drain2: got ov=%b %0d expected 1 4094",
               bus.out_valid, recon(bus.pp_o, bus.neg_o));
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || recon(bus.pp_o, bus.neg_o) !== -64'sd3) begin
      errors++;
      $display("FAIL bp_drain3: got ov=%b %0d expected 1 -3",
               bus.out_valid, recon(bus.pp_o, bus.neg_o));
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_random();
    longint expq[$];
    longint e;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while (got < 1000 && cyc < 20000) begin
      bus.in_valid  = (sent < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      bus.a_i       = 12'($urandom);
      bus.b_i       = 12'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #2;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious: got output expected none");
        end else begin
          e = expq.pop_front();
          if (recon(bus.pp_o, bus.neg_o) !== e) begin
            errors++;
            $display("FAIL rnd_product: got %0d expected %0d",
                     recon(bus.pp_o, bus.neg_o), e);
          end
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(longint'($signed(bus.a_i)) * longint'($signed(bus.b_i)));
        sent++;
      end
      step();
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got != 1000 || expq.size() != 0) begin
      errors++;
      $display("FAIL rnd_count: got %0d left %0d expected 1000 0", got, expq.size());
    end
  endtask

  task automatic test_reset_mid();
    logic ov, rdy;
    pp_t pp;
    logic [NPP-1:0] ng;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a_i = 12'h055;
    bus.b_i = 12'h0AA;
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill: got %b expected 1", bus.out_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.pp_o !== '0 || bus.neg_o !== '0) begin
      errors++;
      $display("FAIL mid_async: got ov=%b pp=%h neg=%b expected 0 0 0",
               bus.out_valid, bus.pp_o, bus.neg_o);
    end
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_spurious%0d: got %b expected 0", k, bus.out_valid);
      end
    end
    apply(12'h002, 12'h003, ov, pp, ng, rdy);
    checks++;
    if (ov !== 1'b1 || recon(pp, ng) !== 64'sd6) begin
      errors++;
      $display("FAIL mid_recover: got ov=%b %0d expected 1 6", ov, recon(pp, ng));
    end
  endtask

  initial begin
    test_reset();
    test_rows();
    test_corner();
    test_negmul();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
